// File: rtl/bus_switch_arbiter.sv
// bus_switch_arbiter
//   Round-robin arbiter that sequences N requesters onto one shared bus, each
//   requester driving the bus through its own tri-state switch. Produces
//   registered one-hot switch enables, inserts TURNAROUND dead cycles between
//   owners so two switches never drive together, and optionally preempts an
//   owner after MAX_HOLD consecutive grant cycles when someone else waits.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   req[N]       per-requester request level
//   grant[N]     one-hot switch enables (registered)
//   grant_valid  high when any grant bit is high
//   grant_id     index of current owner, 0 when grant_valid is low
//   preempt      one-cycle pulse when the owner is forcibly released
module bus_switch_arbiter #(
  parameter int N          = 4,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 8,
  localparam int IDW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   grant,
  output logic           grant_valid,
  output logic [IDW-1:0] grant_id,
  output logic           preempt
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [3:0]    TURN_LAST = 4'(TURNAROUND - 1);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [HW-1:0]  hold_cnt;
  logic [3:0]     turn_cnt;

  logic           any_req;
  logic           owner_req;
  logic           other_req;
  logic           hold_expired;
  logic           select_now;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] next_ptr;

  // First requester found scanning circularly from p.
  function automatic logic [IDW-1:0] pick(input logic [N-1:0] r,
                                          input logic [IDW-1:0] p);
    logic        found;
    logic [31:0] idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(p) + i) % 32'(N);
      if (!found && r[IDW'(idx)]) begin
        pick  = IDW'(idx);
        found = 1'b1;
      end
    end
  endfunction

  function automatic logic [N-1:0] onehot(input logic [IDW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  always_comb begin
    any_req      = |req;
    // grant is one-hot on the owner, so masking with it isolates the owner
    owner_req    = |(req & grant);
    other_req    = |(req & ~grant);
    hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) && other_req;
    select_now   = (state == IDLE) || ((state == TURN) && (turn_cnt == TURN_LAST));
    winner       = pick(req, ptr);
    next_ptr     = (grant_id == IDW'(N - 1)) ? '0 : grant_id + IDW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      preempt     <= 1'b0;
      ptr         <= '0;
      hold_cnt    <= '0;
      turn_cnt    <= '0;
    end else begin
      preempt <= 1'b0;
      case (state)
        GRANT: begin
          // A release on the same edge as an expiring hold wins: preempt only
          // fires while the owner still requests.
          if (!owner_req || hold_expired) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            preempt     <= owner_req;
            ptr         <= next_ptr;
            turn_cnt    <= '0;
            state       <= TURN;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        IDLE, TURN: begin
          if (select_now) begin
            if (any_req) begin
              grant       <= onehot(winner);
              grant_valid <= 1'b1;
              grant_id    <= winner;
              hold_cnt    <= '0;
              state       <= GRANT;
            end else begin
              state <= IDLE;
            end
          end else begin
            turn_cnt <= turn_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_switch_arbiter.sv
module tb_bus_switch_arbiter;

  logic       clk;
  logic       rst_a, rst_b, rst_c;
  logic [3:0] req_a, req_b, req_c;
  logic [3:0] grant_a, grant_b, grant_c;
  logic       valid_a, valid_b, valid_c;
  logic [1:0] id_a, id_b, id_c;
  logic       preempt_a, preempt_b, preempt_c;

  int checks = 0;
  int errors = 0;

  logic [3:0] prev_c;
  int         zero_run_c;

  bus_switch_arbiter #(.N(4), .TURNAROUND(1), .MAX_HOLD(8)) dut_a (
    .clk(clk), .rst(rst_a), .req(req_a), .grant(grant_a),
    .grant_valid(valid_a), .grant_id(id_a), .preempt(preempt_a)
  );

  bus_switch_arbiter #(.N(4), .TURNAROUND(1), .MAX_HOLD(0)) dut_b (
    .clk(clk), .rst(rst_b), .req(req_b), .grant(grant_b),
    .grant_valid(valid_b), .grant_id(id_b), .preempt(preempt_b)
  );

  bus_switch_arbiter #(.N(4), .TURNAROUND(3), .MAX_HOLD(8)) dut_c (
    .clk(clk), .rst(rst_c), .req(req_c), .grant(grant_c),
    .grant_valid(valid_c), .grant_id(id_c), .preempt(preempt_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic invariants(input string tag, input logic [3:0] g, input logic v,
                            input logic [1:0] id);
    logic [1:0] exp_id;
    exp_id = 2'd0;
    for (int i = 0; i < 4; i++)
      if (g[i]) exp_id = 2'(i);
    check({tag, "_onehot0"}, 32'($onehot0(g)), 32'd1);
    check({tag, "_valid"}, 32'(v), 32'(|g));
    check({tag, "_id"}, 32'(id), 32'(exp_id));
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    invariants("inv_a", grant_a, valid_a, id_a);
    invariants("inv_b", grant_b, valid_b, id_b);
    invariants("inv_c", grant_c, valid_c, id_c);
    if (grant_c != 4'b0000 && grant_c != prev_c)
      check("gap_c", 32'(zero_run_c >= 3 || zero_run_c == -1), 32'd1);
    if (grant_c == 4'b0000) begin
      if (zero_run_c >= 0) zero_run_c++;
    end else begin
      zero_run_c = 0;
    end
    prev_c = grant_c;
  endtask

  task automatic expect_a(input string tag, input logic [3:0] g, input logic p);
    check({tag, "_grant"}, 32'(grant_a), 32'(g));
    check({tag, "_preempt"}, 32'(preempt_a), 32'(p));
  endtask

  task automatic reset_a();
    rst_a = 1'b0;
    tick();
    rst_a = 1'b1;
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    req_a = '0; req_b = '0; req_c = '0;
    prev_c = '0;
    zero_run_c = -1;   // no owner yet, so no gap to enforce
    tick();
    tick();

    // reset state
    check("rst_grant_a", 32'(grant_a), 32'd0);
    check("rst_valid_a", 32'(valid_a), 32'd0);
    check("rst_id_a", 32'(id_a), 32'd0);
    check("rst_preempt_a", 32'(preempt_a), 32'd0);
    check("rst_grant_c", 32'(grant_c), 32'd0);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

    // 1: single requester, one-cycle latency, one TURN cycle, then idle
    req_a = 4'b0001;
    tick();
    expect_a("t1_g1", 4'b0001, 1'b0);
    check("t1_id", 32'(id_a), 32'd0);
    tick(); tick(); tick();
    expect_a("t1_g4", 4'b0001, 1'b0);
    req_a = 4'b0000;
    tick();
    expect_a("t1_turn", 4'b0000, 1'b0);
    tick();
    expect_a("t1_idle", 4'b0000, 1'b0);

    // 2: all requesting, each owner holds 2 cycles, order wraps 0..3,0
    reset_a();
    req_a = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] exp_g;
      exp_g = 4'b0001 << (k % 4);
      tick();
      expect_a("t2_first", exp_g, 1'b0);
      tick();
      expect_a("t2_second", exp_g, 1'b0);
      req_a = 4'b1111 & ~exp_g;
      tick();
      expect_a("t2_dead", 4'b0000, 1'b0);
      req_a = 4'b1111;
    end

    // 3: preemption after 8 grant cycles, then hand back to requester 0
    reset_a();
    req_a = 4'b0001;
    tick();
    expect_a("t3_g1", 4'b0001, 1'b0);
    req_a = 4'b0101;
    for (int k = 2; k <= 8; k++) begin
      tick();
      expect_a("t3_hold", 4'b0001, 1'b0);
    end
    tick();
    expect_a("t3_preempt", 4'b0000, 1'b1);
    tick();
    expect_a("t3_g2", 4'b0100, 1'b0);
    tick();
    expect_a("t3_g2b", 4'b0100, 1'b0);
    req_a = 4'b0001;
    tick();
    expect_a("t3_rel", 4'b0000, 1'b0);
    tick();
    expect_a("t3_back", 4'b0001, 1'b0);

    // release on the same edge the hold expires: plain release, no preempt
    reset_a();
    req_a = 4'b0011;
    tick();
    expect_a("t3b_g1", 4'b0001, 1'b0);
    for (int k = 2; k <= 8; k++) tick();
    expect_a("t3b_g8", 4'b0001, 1'b0);
    req_a = 4'b0010;
    tick();
    expect_a("t3b_rel", 4'b0000, 1'b0);
    tick();
    expect_a("t3b_next", 4'b0010, 1'b0);

    // 4: MAX_HOLD=0 never preempts
    req_b = 4'b0011;
    tick();
    check("t4_first", 32'(grant_b), 32'h1);
    for (int k = 0; k < 50; k++) begin
      tick();
      check("t4_grant", 32'(grant_b), 32'h1);
      check("t4_preempt", 32'(preempt_b), 32'h0);
    end
    req_b = '0;

    // 5: reset mid-grant, ptr restarts at 0, no TURN afterwards
    reset_a();
    req_a = 4'b0100;
    tick();
    expect_a("t5_own2", 4'b0100, 1'b0);
    req_a = 4'b0110;
    tick();
    expect_a("t5_own2b", 4'b0100, 1'b0);
    rst_a = 1'b0;
    tick();
    expect_a("t5_rst", 4'b0000, 1'b0);
    check("t5_rst_id", 32'(id_a), 32'd0);
    rst_a = 1'b1;
    tick();
    expect_a("t5_after", 4'b0010, 1'b0);
    check("t5_after_id", 32'(id_a), 32'd1);
    req_a = '0;

    // 6: TURNAROUND=3 gives exactly three dead cycles
    req_c = 4'b0010;
    tick();
    check("t6_own1", 32'(grant_c), 32'h2);
    req_c = 4'b1010;
    tick();
    check("t6_own1b", 32'(grant_c), 32'h2);
    req_c = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t6_dead", 32'(grant_c), 32'h0);
    end
    tick();
    check("t6_own3", 32'(grant_c), 32'h8);

    // random traffic on the long-turnaround instance; invariants every cycle
    for (int k = 0; k < 1000; k++) begin
      req_c = 4'($urandom_range(0, 15));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_switch_arbiter.md
Name: bus_switch_arbiter

Overview:
- Round-robin arbiter that sequences N requesters onto one shared bus, where each requester drives the bus through its own 1-bit-enable tri-state switch.
- Produces the one-hot switch enables and guarantees that at most one enable is high in any cycle.
- Inserts dead (turnaround) cycles between owners so two switches never drive the bus together.
- Sits between the Intcode fetch, operand-read and write-back units and the shared memory or data bus.

Parameters:
- N, 4, number of requesters (2..8).
- TURNAROUND, 1, dead cycles with all enables low between two grants (1..15).
- MAX_HOLD, 8, maximum consecutive GRANT cycles before preemption when another request is pending; 0 disables preemption.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-low reset: rst==0 at a rising clk edge resets the block.
- req  input  N  per-requester request level; held high while the requester wants the bus.
- grant  output  N  one-hot switch enables, registered; bit i drives the Enable pin of requester i's switch.
- grant_valid  output  1  high when any grant bit is high.
- grant_id  output  clog2(N) (min 1)  index of the current owner; 0 when grant_valid is low.
- preempt  output  1  one-cycle pulse when the current owner is forcibly released.

Behaviour:
- Reset (rst==0 at the edge):
  - state=IDLE, grant=0, grant_valid=0, grant_id=0, preempt=0.
  - Round-robin pointer ptr=0, hold_cnt=0, turn_cnt=0.
  - Takes effect regardless of state, including mid-GRANT: grant drops on that same edge, and no TURN cycles are inserted after reset.
- All outputs are registered; there are no combinational paths from req to grant.
- Winner selection: the first i with req[i]==1 scanning ptr, ptr+1, …, N-1, 0, …, ptr-1 (circular).
- States:
  - IDLE
    - All grants low.
    - If any req is high, register the winner: grant=onehot(w), grant_id=w, hold_cnt=0, go to GRANT.
    - Latency: req sampled high at edge k gives grant high after edge k (visible in cycle k+1).
  - GRANT
    - grant is stable; hold_cnt increments each cycle, saturating.
    - Normal release: if req[owner]==0 at an edge, clear grant on that edge, set ptr=(owner+1) mod N, turn_cnt=0, go to TURN.
    - Preemption: if MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, and any other req bit is high, clear grant, pulse preempt for exactly one cycle, set ptr=(owner+1) mod N, go to TURN.
    - Preemption needs no cooperation from the preempted requester. If it keeps req high, it re-competes with the lowest priority.
    - If there is no other request, the owner keeps the bus indefinitely; hold_cnt saturates at MAX_HOLD-1.
  - TURN
    - All grants low for exactly TURNAROUND cycles.
    - On the edge ending the last TURN cycle:
      - if any req is high, grant the winner directly (go to GRANT with hold_cnt=0);
      - else go to IDLE.
- Wrap-around: ptr wraps from N-1 to 0.
- Requests raised during GRANT or TURN are only arbitrated at the next selection point; no request is lost while it stays high.
- Simultaneous release and preemption on the same edge: treat it as a normal release (preempt stays 0).
- A requester dropping req during TURN or IDLE has no effect. A request pulsed for 1 cycle outside a selection point is not remembered (level-sensitive).
- Invariants, checked every cycle:
  - $onehot0(grant).
  - grant_valid == |grant.
  - Any owner change is separated by at least TURNAROUND cycles with grant==0.

Test Plan:
1. Reset, then req=4'b0001 at cycle 2 → grant=0001, grant_id=0 from cycle 3. Drop req at cycle 6 → grant=0 in cycle 7 (1 TURN cycle), IDLE in cycle 8.
2. req=4'b1111 held, each owner releases after 2 cycles then re-requests:
   - grant order is 0001, 0010, 0100, 1000, 0001;
   - there is exactly one zero cycle between owners.
3. Preemption: req0 held forever, req2 raised at cycle 3 (MAX_HOLD=8):
   - grant0 lasts 8 cycles;
   - preempt pulses for 1 cycle;
   - 1 dead cycle follows, then grant=0100;
   - after req2 drops, grant returns to 0001.
4. MAX_HOLD=0, req0 held 50 cycles while req1 high → grant stays 0001 for all 50 cycles and preempt never asserts.
5. Reset mid-GRANT (owner 2, rst=0 for 1 cycle) → grant=0 on that edge. With req=4'b0110 still high after reset, the next grant is 0010 (ptr restarted at 0) one cycle later, with no TURN.
6. TURNAROUND=3, owner 1 releases while req3 is pending → grant is zero for exactly 3 cycles, then grant=1000. The $onehot0 assertion holds throughout a 1000-cycle random req run.
